mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencer for the memory stage's data-bus access. It accepts one load/store per memory-stage instruction and issues a single data-bus request with the correct size, strobe and lane-aligned write data. It then waits out the bus handshake, stalling the pipeline meanwhile. It returns lane-extracted, sign/zero-extended load data with a one-cycle done pulse. It sits beside `memory`, between the E/M register contents and the data bus, and feeds `m_w_reg` load data.

## Interface
- No parameters; address and data are 32 bits.
- clk  in  1  clock
- resetn  in  1  synchronous reset, active low
- mem_valid  in  1  memory-stage instruction present
- mem_load  in  1  instruction is a load
- mem_store  in  1  instruction is a store (never both with mem_load)
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- mem_unsigned  in  1  zero-extend load result (lbu/lhu)
- mem_addr  in  32  effective address (alu_result)
- mem_wdata  in  32  store data (rt_word), low-aligned
- stall  out  1  hold the pipeline at and before the memory stage
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  extended load data, valid while done=1
- misalign  out  1  one-cycle pulse: access rejected, no bus traffic
- dreq_valid  out  1  bus request valid
- dreq_addr  out  32  byte address, passed unmodified
- dreq_size  out  2  copy of the access size
- dreq_strobe  out  4  byte write enables, 0000 for loads
- dreq_data  out  32  lane-aligned write data
- dresp_addr_ok  in  1  request accepted this cycle
- dresp_data_ok  in  1  data phase complete this cycle
- dresp_data  in  32  raw read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - An access is `mem_valid & (mem_load | mem_store)`.
  - Aligned access: latch addr, size, unsigned flag, strobe and shifted data; go to REQ.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): pulse misalign the next cycle and stay in IDLE.
- **REQ**
  - dreq_valid=1; all dreq_* fields held stable.
  - addr_ok & data_ok together: capture data and go to DONE.
  - addr_ok alone: go to WAIT.
  - Neither: stay in REQ.
- **WAIT**
  - dreq_valid=0.
  - data_ok: capture data and go to DONE.
  - data_ok with no prior addr_ok is ignored in REQ.
- **DONE**
  - done=1 and stall=0 for one cycle; return to IDLE.
  - The pipeline advances on this edge, so IDLE sees the next instruction.
- **stall**
  - Combinational: 1 in REQ and WAIT.
  - Also 1 in IDLE when an aligned access is present.
  - 0 in DONE, and 0 in IDLE for non-memory or misaligned instructions.
- **Store strobe and data**
  - Byte: strobe 0001<<addr[1:0]; data is the byte replicated ×4.
  - Half: strobe 0011<<(2·addr[1]); data is the half replicated ×2.
  - Word: strobe 1111; data unchanged.
- **Load extraction**
  - The raw word is shifted right by 8·addr[1:0].
  - Byte and half results are sign-extended, or zero-extended when unsigned.
  - The result is registered into rdata at capture.
  - rdata holds its value until the next capture.
  - rdata is 0 after store completion.
- **Reset** (resetn=0 at an edge, any state): state=IDLE; all registered outputs 0, including dreq_valid, done, misalign, rdata, dreq_*. Outstanding bus transactions are abandoned, and the bus model is reset together with this block.

## Timing
- dreq_*, done, rdata and misalign are registered; stall is combinational from state and inputs.
- Minimum access latency is 3 cycles from accept to pipeline advance:
  - cycle 0: IDLE accept;
  - cycle 1: REQ with addr_ok & data_ok;
  - cycle 2: DONE.
- Each cycle of addr_ok delay adds one REQ cycle; each cycle of data_ok delay adds one WAIT cycle.
- dreq_valid rises the cycle after accept and falls on the edge after addr_ok. It is never asserted for two different accesses back-to-back without an intervening DONE.
- Only one outstanding request at a time; no pipelining of bus requests.
- mem_* inputs are sampled only in IDLE; later changes are ignored until DONE.

## Test plan
- **Word load, zero wait:** addr 0x1000, bus returns 0xDEADBEEF with addr_ok & data_ok in the first REQ cycle → dreq_valid=1 for exactly 1 cycle, strobe 0000, done in cycle 2, rdata=0xDEADBEEF, stall high for cycles 0–1.
- **Byte loads:** signed byte at addr 0x1003 on word 0x80FF_0000 → rdata=0xFFFFFF80; the same access unsigned → 0x00000080.
- **Half store with delays:** addr 0x2002, wdata 0x0000ABCD, addr_ok after 2 cycles, data_ok after 3 more → strobe 1100, dreq_data 0xABCDABCD, dreq_valid high 3 cycles, done at cycle 7, stall low only in DONE.
- **Misaligned:** word load at 0x1001 → no dreq_valid, misalign pulses once, stall stays 0, done stays 0.
- **Reset mid-access:** resetn low while in WAIT → next cycle state IDLE, all outputs 0. A late data_ok after reset produces no done.
- **Back-to-back:** store then load in consecutive instructions → two separate REQ phases with a DONE→IDLE gap between them, and correct strobes for each.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-bus request/response bundle between the memory-stage access sequencer and the bus.
// master = sequencer side (drives requests), slave = bus side (drives responses).
interface mem_access_ctrl_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [1:0]        dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: one data-bus request per instruction, pipeline stall
// while the handshake is outstanding, lane-extracted and extended load data on completion.
module mem_access_ctrl (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_valid,
    input  logic                mem_load,
    input  logic                mem_store,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    output logic                stall,
    output logic                done,
    output logic [31:0]         rdata,
    output logic                misalign,
    mem_access_ctrl_if.master   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic                acc_load;
    logic                acc_unsigned;

    logic                access;
    logic                misaligned;
    logic                aligned_access;
    logic [STRB_W-1:0]   lane_strobe;
    logic [DATA_W-1:0]   lane_data;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_ext;

    // Sizes 2 and 3 are both word accesses, so size[1] alone marks a word.
    assign access         = mem_valid & (mem_load | mem_store);
    assign misaligned     = ((mem_size == 2'd1) & mem_addr[0]) |
                            (mem_size[1] & (mem_addr[1:0] != 2'b00));
    assign aligned_access = access & ~misaligned;

    assign stall = (state == S_REQ) | (state == S_WAIT) |
                   ((state == S_IDLE) & aligned_access);

    // Store lane placement: strobe selects lanes, data is replicated across all lanes.
    always_comb begin
        lane_strobe = 4'b1111;
        lane_data   = mem_wdata;
        case (mem_size)
            2'd0: begin
                lane_strobe = 4'b0001 << mem_addr[1:0];
                lane_data   = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                lane_strobe = mem_addr[1] ? 4'b1100 : 4'b0011;
                lane_data   = {2{mem_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!mem_store) begin
            lane_strobe = '0;
        end
    end

    // Load extraction uses the latched request fields, not the live pipeline inputs.
    always_comb begin
        shifted  = bus.dresp_data >> {bus.dreq_addr[1:0], 3'b000};
        load_ext = shifted;
        case (bus.dreq_size)
            2'd0: load_ext = acc_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = acc_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
        if (!acc_load) begin
            load_ext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            acc_load        <= 1'b0;
            acc_unsigned    <= 1'b0;
            done            <= 1'b0;
            misalign        <= 1'b0;
            rdata           <= '0;
            bus.dreq_valid  <= 1'b0;
            bus.dreq_addr   <= '0;
            bus.dreq_size   <= '0;
            bus.dreq_strobe <= '0;
            bus.dreq_data   <= '0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access && misaligned) begin
                        misalign <= 1'b1;
                    end else if (access) begin
                        acc_load        <= mem_load;
                        acc_unsigned    <= mem_unsigned;
                        bus.dreq_valid  <= 1'b1;
                        bus.dreq_addr   <= mem_addr;
                        bus.dreq_size   <= mem_size;
                        bus.dreq_strobe <= lane_strobe;
                        bus.dreq_data   <= lane_data;
                        state           <= S_REQ;
                    end
                end
                // data_ok before addr_ok belongs to no request of ours and is dropped.
                S_REQ: begin
                    if (bus.dresp_addr_ok) begin
                        bus.dreq_valid <= 1'b0;
                        if (bus.dresp_data_ok) begin
                            rdata <= load_ext;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dresp_data_ok) begin
                        rdata <= load_ext;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
